// File: rtl/sobel_axis_out_bridge.sv
// Ready/valid source -> stall-driven Sobel pipeline -> AXI-Stream master, with beat tagging and an output FIFO.
// Define FRAME_CNT_EN to add the frame_count / frame_done outputs.
module sobel_axis_out_bridge #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
    parameter int LATENCY         = 20,
    parameter int FIFO_DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  stall,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  busy
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count,
    output logic                  frame_done
`endif
);

    localparam int BEATS_PER_LINE = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int COL_W   = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int ROW_W   = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
    localparam int FL_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int INF_W   = $clog2(LATENCY + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int ENTRY_W = DATA_WIDTH + 2;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               active_q;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [FL_W-1:0]    flush_q, flush_d;
    logic [LATENCY-1:0] tag_v_q, tag_l_q, tag_u_q;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

    logic [OCC_W-1:0]   occupancy;
    logic               space;
    logic               accept;
    logic               advance;
    logic               tag_in_l, tag_in_u;
    logic               leave_v, leave_l, leave_u;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    // Beats already accepted but not yet popped are either in the pipeline or in the FIFO;
    // refusing new beats once that total reaches the depth reserves a FIFO slot for every one.
    assign occupancy = OCC_W'(cnt_q) + OCC_W'(inflight_q);
    assign space     = occupancy < OCC_W'(FIFO_DEPTH);

    always_comb begin
        s_ready = 1'b0;
        stall   = 1'b1;
        accept  = 1'b0;
        state_d = state_q;
        flush_d = flush_q;
        col_d   = col_q;
        row_d   = row_q;
        if (active_q) begin
            case (state_q)
                ST_RUN: begin
                    s_ready = space;
                    accept  = s_valid & space;
                    stall   = ~accept;
                    if (accept) begin
                        if (col_q == COL_W'(BEATS_PER_LINE - 1)) begin
                            col_d = '0;
                            if (row_q == ROW_W'(IMAGE_DIM - 1)) begin
                                row_d   = '0;
                                state_d = ST_FLUSH;
                                flush_d = '0;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    stall = ~space;
                    if (space) begin
                        if (flush_q == FL_W'(LATENCY - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            flush_d = flush_q + FL_W'(1);
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign advance  = ~stall;
    assign tag_in_l = accept & (col_q == COL_W'(BEATS_PER_LINE - 1));
    assign tag_in_u = accept & (col_q == '0) & (row_q == '0);
    assign leave_v  = tag_v_q[LATENCY-1];
    assign leave_l  = tag_l_q[LATENCY-1];
    assign leave_u  = tag_u_q[LATENCY-1];
    assign push     = advance & leave_v;
    assign pop      = m_tvalid & m_tready;

    always_comb begin
        inflight_d = inflight_q;
        if (advance) begin
            case ({accept, leave_v})
                2'b10:   inflight_d = inflight_q + INF_W'(1);
                2'b01:   inflight_d = inflight_q - INF_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // active_q keeps s_ready low and stall high from reset until the first clock after release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_RUN;
            active_q   <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            flush_q    <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= 1'b1;
            col_q      <= col_d;
            row_q      <= row_d;
            flush_q    <= flush_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tag_v_q <= '0;
            tag_l_q <= '0;
            tag_u_q <= '0;
        end else if (advance) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_l_q[i] <= tag_l_q[i-1];
                tag_u_q[i] <= tag_u_q[i-1];
            end
            tag_v_q[0] <= accept;
            tag_l_q[0] <= tag_in_l;
            tag_u_q[0] <= tag_in_u;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pipe_data, leave_l, leave_u};
        end
    end

    // Head outputs are forced to zero while empty so nothing uninitialised reaches the port.
    assign head     = mem_q[rd_ptr_q];
    assign m_tvalid = (cnt_q != '0);
    assign m_tdata  = m_tvalid ? head[ENTRY_W-1:2] : '0;
    assign m_tlast  = m_tvalid & head[1];
    assign m_tuser  = m_tvalid & head[0];
    assign busy     = (state_q == ST_FLUSH) | m_tvalid;

`ifdef FRAME_CNT_EN
    logic [ROW_W-1:0] out_row_q;
    logic             line_pop;

    assign line_pop   = pop & m_tlast;
    assign frame_done = line_pop & (out_row_q == ROW_W'(IMAGE_DIM - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_row_q   <= '0;
            frame_count <= '0;
        end else if (line_pop) begin
            if (frame_done) begin
                out_row_q   <= '0;
                frame_count <= frame_count + 16'd1;
            end else begin
                out_row_q <= out_row_q + ROW_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sobel_axis_out_bridge.sv
// Scoreboard bench for sobel_axis_out_bridge with a small 8x8 image and a delay-line filter model.
// Also exercises frame_count / frame_done when FRAME_CNT_EN is defined.
module tb_sobel_axis_out_bridge;

    localparam int PPB   = 4;
    localparam int DIM   = 8;
    localparam int DW    = 8*PPB;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int BPL   = DIM / PPB;
    localparam int FRAME = BPL * DIM;

    logic          clk;
    logic          aresetn;
    logic          s_valid;
    logic          s_ready;
    logic          stall;
    logic [DW-1:0] pipe_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic          busy;
`ifdef FRAME_CNT_EN
    logic [15:0]   frame_count;
    logic          frame_done;
`endif

    logic [DW-1:0] s_data;
    logic [DW-1:0] stage [LAT];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        int            idx;
    } beat_t;

    beat_t sb[$];

    int checks;
    int errors;
    int inIdx;
    int accTotal;
    int inFlush;
    int flushAdv;
    int fullSeen;
    int popsSinceRst;
    int tuserSinceRst;
    int framesOut;
    int doneSeen;
    int advData;

    sobel_axis_out_bridge #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM(DIM),
        .DATA_WIDTH(DW),
        .LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .stall(stall),
        .pipe_data(pipe_data),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .busy(busy)
`ifdef FRAME_CNT_EN
        ,
        .frame_count(frame_count),
        .frame_done(frame_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The filter is a plain delay line that only moves on non-stalled cycles.
    always @(posedge clk) begin
        if (!stall) begin
            stage[0] <= s_data;
            for (int i = 1; i < LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end
    assign pipe_data = stage[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_s_ready"},  32'(s_ready),  0);
        checkOutput({pfx, "_stall"},    32'(stall),    1);
        checkOutput({pfx, "_m_tvalid"}, 32'(m_tvalid), 0);
        checkOutput({pfx, "_m_tlast"},  32'(m_tlast),  0);
        checkOutput({pfx, "_m_tuser"},  32'(m_tuser),  0);
        checkOutput({pfx, "_m_tdata"},  m_tdata,       0);
        checkOutput({pfx, "_busy"},     32'(busy),     0);
    endtask

    // One clock: drive at the falling edge, observe just after, account for the coming rising edge.
    task automatic applyStimulus(input logic v, input logic r);
        logic  accNow;
        logic  popNow;
        logic  expDone;
        beat_t e;
        @(negedge clk);
        if (advData != 0) begin
            s_data  = $urandom;
            advData = 0;
        end
        s_valid  = v;
        m_tready = r;
        #1;
        if (inFlush != 0) begin
            if (s_ready) begin
                checkOutput("flushAdvances", flushAdv, LAT);
                inFlush = 0;
            end else if (!stall) begin
                flushAdv++;
            end
        end
        if (inFlush == 0) begin
            checkOutput("stallRule", 32'(stall), 32'(!(s_valid && s_ready)));
        end
        if (sb.size() >= DEPTH) begin
            fullSeen = 1;
            checkOutput("fullReady", 32'(s_ready), 0);
            checkOutput("fullStall", 32'(stall), 1);
        end
        if (sb.size() > DEPTH) begin
            checkOutput("occupancy", sb.size(), DEPTH);
        end
        accNow  = s_valid && s_ready;
        popNow  = m_tvalid && m_tready;
        expDone = 1'b0;
        if (popNow) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedBeat", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("tdata", m_tdata, e.data);
                checkOutput("tlast", 32'(m_tlast), 32'(e.last));
                checkOutput("tuser", 32'(m_tuser), 32'(e.user));
                popsSinceRst++;
                if (m_tuser) tuserSinceRst++;
                expDone = (e.idx == FRAME - 1);
                if (expDone) framesOut++;
            end
        end
`ifdef FRAME_CNT_EN
        checkOutput("frameDone", 32'(frame_done), 32'(expDone));
        if (frame_done) doneSeen++;
`endif
        if (accNow) begin
            sb.push_back('{s_data, (inIdx % BPL) == BPL - 1, inIdx == 0, inIdx});
            accTotal++;
            advData = 1;
            if (inIdx == FRAME - 1) begin
                inIdx    = 0;
                inFlush  = 1;
                flushAdv = 0;
            end else begin
                inIdx++;
            end
        end
    endtask

    task automatic runBeats(input int n, input int pattern, input int lowStart, input int lowLen);
        int   target;
        int   cyc;
        logic v;
        logic r;
        target = accTotal + n;
        cyc    = 0;
        while (accTotal < target && cyc < 3000) begin
            v = (pattern == 1) ? (cyc % 2 == 0) : 1'b1;
            r = !(cyc >= lowStart && cyc < lowStart + lowLen);
            applyStimulus(v, r);
            cyc++;
        end
        if (accTotal < target) checkOutput("acceptTimeout", accTotal, target);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            applyStimulus(1'b0, 1'b1);
            cyc++;
        end
        if (sb.size() != 0) checkOutput("drainTimeout", sb.size(), 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busyIdle", 32'(busy), 0);
        checkOutput("tvalidIdle", 32'(m_tvalid), 0);
    endtask

    task automatic midReset();
        @(negedge clk);
        s_valid  = 1'b1;
        m_tready = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        checkResetOutputs("midRst");
        sb.delete();
        inIdx         = 0;
        inFlush       = 0;
        popsSinceRst  = 0;
        tuserSinceRst = 0;
        framesOut     = 0;
        doneSeen      = 0;
        advData       = 1;
        @(posedge clk);
        @(negedge clk);
        #2;
        aresetn = 1'b1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        inIdx         = 0;
        accTotal      = 0;
        inFlush       = 0;
        flushAdv      = 0;
        fullSeen      = 0;
        popsSinceRst  = 0;
        tuserSinceRst = 0;
        framesOut     = 0;
        doneSeen      = 0;
        advData       = 0;
        aresetn       = 1'b0;
        s_valid       = 1'b0;
        m_tready      = 1'b0;
        s_data        = $urandom;

        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("rst");
        #1;
        aresetn = 1'b1;

        // Two back-to-back frames with the source always valid, crossing one flush.
        runBeats(2*FRAME, 0, 0, 0);
        // A frame with the source valid only every other cycle.
        runBeats(FRAME, 1, 0, 0);
        // A frame with the sink stalled for 100 cycles early on.
        runBeats(FRAME, 0, 4, 100);
        checkOutput("fifoFilled", fullSeen, 1);
        drain();

        // Reset in the middle of a frame, then three clean frames.
        runBeats(4, 0, 0, 0);
        midReset();
        runBeats(3*FRAME, 0, 0, 0);
        drain();
        checkOutput("beatsAfterReset", popsSinceRst, 3*FRAME);
        checkOutput("tuserAfterReset", tuserSinceRst, 3);
        checkOutput("framesOut", framesOut, 3);
`ifdef FRAME_CNT_EN
        checkOutput("frameCount", 32'(frame_count), 3);
        checkOutput("frameDonePulses", doneSeen, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_axis_out_bridge.md
Name: sobel_axis_out_bridge

Overview:
- Sits between an upstream ready/valid pixel-beat source and the stall-driven Sobel filter pipeline, and converts the filter's output back to an AXI-Stream master.
- Generates the filter's stall and the source's ready.
- Tracks which pipeline slots carry real beats and tags each beat with line-end (tlast) and frame-start (tuser).
- Drains the filter pipeline at end of frame and buffers results in an output FIFO, so downstream backpressure never loses data.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat.
- IMAGE_DIM, 512, image width and height in pixels.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width.
- LATENCY, 20, filter cycles from input beat to output beat, counted in non-stalled cycles. Must be at least 1.
- FIFO_DEPTH, 32, output FIFO entries. Power of 2, greater than LATENCY.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_valid  in  1  source beat valid
- s_ready  out  1  source beat accepted when s_valid & s_ready
- stall  out  1  freeze for the filter pipeline; also gates the filter's input mux
- pipe_data  in  DATA_WIDTH  filter out_frame, sampled on non-stalled cycles
- m_tdata  out  DATA_WIDTH  output beat
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last beat of a line
- m_tuser  out  1  first beat of a frame
- busy  out  1  high while in FLUSH or while the FIFO is non-empty

Behaviour:
- Reset: clk and aresetn as named above. Reset is asynchronous and active-low. All counters, tags, FIFO pointers and FSM are cleared. Reset values: state RUN, s_ready=0, stall=1, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, busy=0.
- Derived constants:
  - BEATS_PER_LINE = IMAGE_DIM/PIXELS_PER_BEAT.
  - col counter runs 0..BEATS_PER_LINE-1; row counter runs 0..IMAGE_DIM-1.
- Tag shift register: LATENCY entries of {v,last,user}. It shifts only on advance cycles (stall=0).
  - Entering tag: v = input accepted this cycle; last = (col==BEATS_PER_LINE-1); user = (col==0 && row==0).
  - inflight = count of set v bits, maintained incrementally rather than by a popcount.
- Space rule: space = (fifo_count + inflight < FIFO_DEPTH), using registered values. This guarantees no FIFO overflow.
- FIFO push: on an advance cycle, if the tag leaving the shift register has v=1, push {pipe_data, last, user} into the FIFO the same cycle.
- FSM:
  - RUN:
    - s_ready = space; stall = ~(s_valid & space).
    - On an accepted beat: increment col and row with wrap.
    - When the accepted beat is col=BEATS_PER_LINE-1 and row=IMAGE_DIM-1, go to FLUSH, clear flush_cnt, and wrap col and row to 0.
  - FLUSH:
    - s_ready = 0; stall = ~space; entering tag v = 0.
    - flush_cnt increments on each advance cycle.
    - When flush_cnt reaches LATENCY-1 on an advance, go to RUN. All frame beats are then in the FIFO or were already popped.
- Output:
  - FIFO head drives m_tdata, m_tlast and m_tuser, with m_tvalid = ~empty.
  - Pop on m_tvalid & m_tready.
  - Push and pop in the same cycle: count unchanged. This is legal even when the FIFO is full, because push can only occur if space reserved the entry.
  - m_tdata, m_tlast and m_tuser hold stable while m_tvalid & ~m_tready.
- Throughput: 1 beat/cycle sustained when s_valid=1, m_tready=1 and the FIFO is not near full. The added output latency beyond the filter's LATENCY is 1 cycle (FIFO registered head).
- Boundaries:
  - s_valid low mid-line: stall=1, tags frozen, no push.
  - m_tready low for a long time: the FIFO fills, then space=0 forces stall=1 and s_ready=0. No data is dropped or duplicated.
  - A source beat that arrives during FLUSH is held off (s_ready=0) until RUN.
  - aresetn low mid-frame clears everything immediately. The first accepted beat after release is tagged tuser=1.

Optional Feature:
- Macro FRAME_CNT_EN.
- When defined:
  - Adds output frame_count (16 bits, reset 0). It increments on the handshake of the beat with m_tlast=1 that closes row IMAGE_DIM-1, counted by an output-side line counter, and wraps at 2^16.
  - Adds output frame_done, a 1-cycle pulse on that same handshake.
- When undefined: neither port exists and there is no related logic.

Test Plan:
- Reset-value check: PIXELS_PER_BEAT=4, IMAGE_DIM=8, LATENCY=3, s_valid=1 and m_tready=1 continuously. Requires 16 beats out in order, where the value is filter output, modelled as input delayed 3 advances. m_tlast on beats 2,4,…,16; m_tuser only on beat 1; busy returns to 0 after the final pop.
- s_valid toggled every other cycle: output sequence identical to the continuous case. stall=1 exactly on cycles with s_valid=0 in RUN.
- m_tready=0 for 100 cycles mid-frame with FIFO_DEPTH=8: stall=1 and s_ready=0 once fifo_count+inflight reaches 8. No beat is lost; the FIFO never exceeds 8 entries; order is preserved after release.
- End of frame with s_valid held high: exactly LATENCY=3 flush advances with s_ready=0. The next frame's first beat is accepted after FLUSH and carries m_tuser=1.
- aresetn pulsed low during beat 5 of a frame: all outputs go to their reset values asynchronously. The next frame emits a full 16 beats starting with tuser=1.
- With FRAME_CNT_EN: 3 back-to-back frames give frame_count=3 and exactly 3 frame_done pulses, each on the last tlast of a frame.
